// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Responder end of the request-unit/cache handshake. It serializes
//            instruction fetches and data reads/writes onto a single-ported
//            RAM and returns one-cycle ihit/dhit pulses with the load data.
// Options  : `define ACCESS_CNT_EN adds icount/dcount hit counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [WORD_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    input  logic              ram_ready
`ifdef ACCESS_CNT_EN
    ,
    output logic [CNT_W-1:0]  icount,
    output logic [CNT_W-1:0]  dcount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DACC = 2'd1,
        S_IACC = 2'd2
    } state_t;

    // Clears the byte offset so the RAM always sees a word address.
    localparam logic [WORD_W-1:0] C_ALIGN_MASK = ~WORD_W'(3);

    state_t              state_q,     state_d;
    logic [WORD_W-1:0]   addr_q,      addr_d;
    logic [WORD_W-1:0]   wdata_q,     wdata_d;
    logic                is_wr_q,     is_wr_d;
    logic                ihit_q,      ihit_d;
    logic                dhit_q,      dhit_d;
    logic [WORD_W-1:0]   iload_q,     iload_d;
    logic [WORD_W-1:0]   dload_q,     dload_d;
    logic                ram_ren_q,   ram_ren_d;
    logic                ram_wen_q,   ram_wen_d;
    logic [WORD_W-1:0]   ram_addr_q,  ram_addr_d;
    logic [WORD_W-1:0]   ram_wdata_q, ram_wdata_d;

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        iload_d     = iload_q;
        dload_d     = dload_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            S_IDLE: begin
                // Hold off for the hit cycle so the requester can drop its enable.
                if (!ihit_q && !dhit_q) begin
                    if (dREN || dWEN) begin
                        addr_d  = daddr;
                        wdata_d = dstore;
                        is_wr_d = dWEN;
                        state_d = S_DACC;
                    end else if (iREN) begin
                        addr_d  = iaddr;
                        is_wr_d = 1'b0;
                        state_d = S_IACC;
                    end
                end
            end
            S_DACC, S_IACC: begin
                ram_addr_d = addr_q & C_ALIGN_MASK;
                if (ram_ren_q || ram_wen_q) begin
                    // Ready only counts once a strobe is actually on the bus.
                    if (ram_ready) begin
                        ram_ren_d = 1'b0;
                        ram_wen_d = 1'b0;
                        state_d   = S_IDLE;
                        if (state_q == S_DACC) begin
                            dhit_d = 1'b1;
                            if (!is_wr_q) begin
                                dload_d = ram_rdata;
                            end
                        end else begin
                            ihit_d  = 1'b1;
                            iload_d = ram_rdata;
                        end
                    end
                end else begin
                    ram_wen_d = (state_q == S_DACC) && is_wr_q;
                    ram_ren_d = !((state_q == S_DACC) && is_wr_q);
                    if ((state_q == S_DACC) && is_wr_q) begin
                        ram_wdata_d = wdata_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            iload_q     <= '0;
            dload_q     <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            iload_q     <= iload_d;
            dload_q     <= dload_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ihit      = ihit_q;
    assign dhit      = dhit_q;
    assign iload     = iload_q;
    assign dload     = dload_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

`ifdef ACCESS_CNT_EN
    logic [CNT_W-1:0] icount_q, icount_d;
    logic [CNT_W-1:0] dcount_q, dcount_d;

    // Counters advance together with the hit pulse they count, wrapping naturally.
    always_comb begin
        icount_d = icount_q + CNT_W'(ihit_d);
        dcount_d = dcount_q + CNT_W'(dhit_d);
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            icount_q <= '0;
            dcount_q <= '0;
        end else begin
            icount_q <= icount_d;
            dcount_q <= dcount_d;
        end
    end

    assign icount = icount_q;
    assign dcount = dcount_q;
`endif

endmodule

`default_nettype wire
